demorgan_response_checker: RTL
==============================

// Module: demorgan_response_checker
// PURPOSE
//  Synthesizable response checker for the De Morgan gate blocks: the observing end of the
//  a/b/c -> d stimulus path. Samples each applied input vector with the DUT output d,
//  compares d against a parameterised golden truth table, and tracks coverage of all 2^N_IN
//  input combinations. Reports error count, first failing vector, timeout, done and pass.
//  Sits beside the gate under test in a board-level self-test wrapper.
// PARAMETERS
//  N_IN      3        number of gate inputs; vector {a,b,c} with a = MSB
//  EXPECT_TT 8'h7F    golden truth table, bit[i] = expected d for input vector i (default NAND3)
//  ERR_W     8        error counter width, saturating
//  TMO_W     10       timeout counter width
//  TMO_MAX   1000     RUN cycles allowed before timeout (must be < 2^TMO_W)
// PORTS
//  clk         in   1          rising-edge clock
//  rst         in   1          synchronous, active-high reset
//  start       in   1          1-cycle pulse: clear results, begin a check run
//  in_valid    in   1          in_vec/d_obs hold a settled sample this cycle
//  in_vec      in   N_IN       applied input vector {a,b,c}
//  d_obs       in   1          observed DUT output d
//  busy        out  1          1 while in RUN
//  done        out  1          1 in DONE (held until next start)
//  pass        out  1          valid when done: full coverage, zero errors, no timeout
//  timeout     out  1          run ended by timeout
//  err_cnt     out  ERR_W      mismatches this run, saturates at all-ones
//  cov_map     out  2^N_IN     bit[i] set once vector i sampled this run
//  first_err   out  N_IN       in_vec of first mismatch (0 if none)
//  first_err_v out  1          first_err is valid
// BEHAVIOUR
//  - Reset (sync, rst=1 at clk edge): state IDLE; every output and internal counter = 0.
//  - FSM IDLE -> RUN on start; RUN -> DONE on full coverage or timeout; DONE -> RUN on start.
//    start in RUN restarts: results cleared, timer reset, stay RUN. rst wins over start.
//  - Entering RUN (edge where start=1): cov_map, err_cnt, first_err(_v), timeout, pass,
//    tmo counter cleared; busy=1, done=0 from next cycle. A sample with in_valid on the
//    same cycle as start is ignored.
//  - In RUN, each in_valid cycle: cov_map[in_vec] <= 1; if d_obs != EXPECT_TT[in_vec] then
//    err_cnt <= sat(err_cnt+1); if first_err_v==0 capture first_err<=in_vec, first_err_v<=1.
//    Repeated vectors counted/checked every time.
//  - Completion: if cov_map | onehot(in_vec) == all-ones on a valid sample, DONE next cycle;
//    pass computed including that sample (1-cycle latency sample -> done/pass).
//  - Timeout: tmo counter increments every RUN cycle; when it reaches TMO_MAX-1 without
//    coverage, DONE next cycle with timeout=1, pass=0. Coverage on the same cycle wins
//    (timeout=0).
//  - IDLE/DONE: in_valid ignored; all results held stable.
//  - err_cnt at 2^ERR_W-1 stays there; pass=0 whenever err_cnt!=0.
//  - Reset mid-RUN: abort, all results cleared, back to IDLE.
// STRUCTURE
//  - Shared package demorgan_pkg: state encodings S_IDLE/S_RUN/S_DONE, function
//    tt_lookup(tt, vec), NAND3_TT=8'h7F / NOR3_TT=8'h01 constants.
//  - One sub-module: sat_counter #(W) (clr, inc -> q, saturating) used for err_cnt;
//    timeout counter and FSM inline.
// TESTING
//  1. rst=1 for 2 cycles -> all outputs 0, busy=0, done=0.
//  2. start, then vectors 0..7 in order with correct NAND3 d -> done=1, pass=1, err_cnt=0,
//     cov_map=8'hFF, one cycle after vector 7 sample.
//  3. start, vectors 0..7 with d wrong for vec 3 and 5 -> err_cnt=2, first_err=3,
//     first_err_v=1, pass=0.
//  4. start, only vectors 0..6 repeated, TMO_MAX=20 -> done after 20 RUN cycles,
//     timeout=1, pass=0, cov_map=8'h7F.
//  5. ERR_W=2, 5 wrong samples then full coverage -> err_cnt=3 (saturated), pass=0.
//  6. rst asserted after 4 samples mid-RUN -> IDLE, cov_map=0; new start then full correct
//     sweep -> pass=1; start in DONE clears results.

Source files
------------

// File: rtl/demorgan_pkg.sv
// Shared definitions for the De Morgan gate response checker: FSM states, golden truth
// tables and the truth-table lookup helper.
package demorgan_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [7:0]  NAND3_TT = 8'h7F;
    localparam logic [7:0]  NOR3_TT  = 8'h01;

    // Widest table tt_lookup accepts; callers zero-extend narrower tables.
    localparam int unsigned TT_MAX_W = 256;

    function automatic logic tt_lookup(input logic [TT_MAX_W-1:0] tt, input logic [7:0] vec);
        return tt[vec];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/demorgan_response_checker.sv
// Observes applied gate input vectors and the gate output, checks each sample against a
// golden truth table and tracks coverage of every input combination over a check run.
module demorgan_response_checker
    import demorgan_pkg::*;
#(
    parameter int unsigned         N_IN      = 3,
    parameter logic [2**N_IN-1:0]  EXPECT_TT = NAND3_TT,
    parameter int unsigned         ERR_W     = 8,
    parameter int unsigned         TMO_W     = 10,
    parameter int unsigned         TMO_MAX   = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [N_IN-1:0]     in_vec,
    input  logic                d_obs,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                timeout,
    output logic [ERR_W-1:0]    err_cnt,
    output logic [2**N_IN-1:0]  cov_map,
    output logic [N_IN-1:0]     first_err,
    output logic                first_err_v
);

    localparam int unsigned NV = 2**N_IN;

    state_e            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [NV-1:0]     cov_q, cov_d;
    logic [N_IN-1:0]   first_err_q, first_err_d;
    logic              first_err_v_q, first_err_v_d;
    logic              timeout_q, timeout_d;
    logic              pass_q, pass_d;

    logic [NV-1:0]     vec_onehot;
    logic              sample, mismatch, full_cov, tmo_hit, err_clr;

    always_comb begin
        vec_onehot         = '0;
        vec_onehot[in_vec] = 1'b1;
        // A sample coinciding with start belongs to no run and is dropped.
        sample   = (state_q == S_RUN) && in_valid && !start;
        mismatch = sample && (d_obs != tt_lookup(TT_MAX_W'(EXPECT_TT), 8'(in_vec)));
        full_cov = sample && ((cov_q | vec_onehot) == '1);
        tmo_hit  = (state_q == S_RUN) && !start && (tmo_q == TMO_W'(TMO_MAX - 1));
    end

    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        cov_d         = cov_q;
        first_err_d   = first_err_q;
        first_err_v_d = first_err_v_q;
        timeout_d     = timeout_q;
        pass_d        = pass_q;
        err_clr       = 1'b0;

        if (start) begin
            state_d       = S_RUN;
            tmo_d         = '0;
            cov_d         = '0;
            first_err_d   = '0;
            first_err_v_d = 1'b0;
            timeout_d     = 1'b0;
            pass_d        = 1'b0;
            err_clr       = 1'b1;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    tmo_d = tmo_q + 1'b1;
                    if (sample) begin
                        cov_d = cov_q | vec_onehot;
                    end
                    if (mismatch && !first_err_v_q) begin
                        first_err_d   = in_vec;
                        first_err_v_d = 1'b1;
                    end
                    // Coverage on the final timer cycle takes priority over timeout.
                    if (full_cov) begin
                        state_d = S_DONE;
                        pass_d  = (err_cnt == '0) && !mismatch;
                    end else if (tmo_hit) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                        pass_d    = 1'b0;
                    end
                end
                S_IDLE, S_DONE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            tmo_q         <= '0;
            cov_q         <= '0;
            first_err_q   <= '0;
            first_err_v_q <= 1'b0;
            timeout_q     <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmo_q         <= tmo_d;
            cov_q         <= cov_d;
            first_err_q   <= first_err_d;
            first_err_v_q <= first_err_v_d;
            timeout_q     <= timeout_d;
            pass_q        <= pass_d;
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (err_clr),
        .inc (mismatch),
        .q   (err_cnt)
    );

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign cov_map     = cov_q;
    assign first_err   = first_err_q;
    assign first_err_v = first_err_v_q;

endmodule
